// File: rtl/risc_mem_wb.sv
// Memory/write-back stage: pass, load or store on an internal word RAM, with a
// registered write-back result, valid/ready handshake and out-of-range counter.
module risc_mem_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [ADDR_W-1:0] addr,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS     = 2'b00,
        OP_LOAD     = 2'b01,
        OP_STORE    = 2'b10,
        OP_PASS_ALT = 2'b11
    } op_e;

    state_e            state;
    op_e               op_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              rd_oob;
    logic              accept;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic [IDX_W-1:0]  idx;

    assign op_q     = op_e'(op);
    assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
    assign idx      = addr[IDX_W-1:0];
    assign accept   = in_valid && in_ready;
    assign is_load  = accept && (op_q == OP_LOAD);
    assign is_store = accept && (op_q == OP_STORE);
    assign busy     = (state != IDLE);

    // In WB the slot frees on the same edge the result retires, so a new op
    // may be taken only when downstream is accepting.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            WB:      in_ready = wb_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // RAM is not reset; writes land on the accept edge, so a load accepted on
    // the following edge already sees the new word.
    always_ff @(posedge clk) begin
        if (is_store && in_range) begin
            mem[idx] <= store_data;
        end
        if (is_load) begin
            rd_data <= mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            err_cnt  <= '0;
            rd_oob   <= 1'b0;
        end else begin
            if ((is_load || is_store) && !in_range && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            case (state)
                IDLE, WB: begin
                    if (state == WB && wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                    if (accept) begin
                        case (op_q)
                            OP_LOAD: begin
                                rd_oob   <= !in_range;
                                wb_valid <= 1'b0;
                                state    <= MEM;
                            end
                            OP_STORE: begin
                                wb_valid <= 1'b0;
                                state    <= IDLE;
                            end
                            default: begin
                                wb_data  <= alu_in;
                                wb_valid <= 1'b1;
                                state    <= WB;
                            end
                        endcase
                    end
                end
                MEM: begin
                    wb_data  <= rd_oob ? '0 : rd_data;
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/risc_mem_wb.md
# risc_mem_wb

Memory/write-back stage directly downstream of the RISC datapath top. It accepts one operation per handshake, carrying an ALU result, store data and a 16-bit data address. It performs the data-memory access on an internal word-addressed RAM and presents a registered write-back result with a valid/ready handshake. A saturating counter records out-of-range memory accesses.

## Interface
- DATA_W, 32, width of ALU result, store data and write-back data
- ADDR_W, 16, width of the data address
- DEPTH, 256, RAM words; legal addresses are 0..DEPTH-1 (word addressed)
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous and active-low
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge
- op  in  2  00 = pass ALU result, 01 = load, 10 = store, 11 = treated as pass
- alu_in  in  DATA_W  ALU result (pass value)
- store_data  in  DATA_W  data written on store
- addr  in  ADDR_W  data address for load/store
- wb_valid  out  1  write-back data valid
- wb_data  out  DATA_W  write-back value
- wb_ready  in  1  downstream accepts wb_data
- busy  out  1  high whenever state is not IDLE
- err_cnt  out  8  count of out-of-range load/store accepts, saturates at 255

## Operation
- States: IDLE, MEM, WB.
- IDLE: in_ready = 1.
  - Pass accept: wb_data <= alu_in, go to WB.
  - Load accept: issue a synchronous RAM read at addr, go to MEM.
  - Store accept: write store_data to RAM[addr] on the accept edge and stay in IDLE. A store produces no wb_valid.
- MEM: in_ready = 0. On the next edge, wb_data <= RAM read data and the state goes to WB.
- WB: wb_valid = 1, and wb_data is held stable until the handshake.
  - in_ready = wb_ready, a combinational pass-through.
  - On a wb_ready edge the result retires. A new operation accepted on the same edge is processed exactly as from IDLE: pass goes to WB, load goes to MEM, store writes and goes to IDLE.
  - With wb_ready = 0 the stage stalls in WB and nothing is accepted.
- Out of range is addr >= DEPTH on a load or store.
  - Store: the write is suppressed.
  - Load: wb_data = 0 after the normal latency.
  - Either case: err_cnt increments by 1, saturating at 255.
  - Pass ops never count.
- Load after store to the same address on consecutive accepts returns the newly stored value, because the write occurs before the read edge.
- op = 11 behaves exactly as pass, with no error.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset (rst = 0) is asynchronous. Required values while it is asserted:
  - state = IDLE, wb_valid = 0, wb_data = 0, err_cnt = 0, busy = 0, in_ready = 1.
  - Any in-flight load or pending write-back is discarded.
- Reset release takes effect on the first rising edge with rst = 1.
- Latency from accept edge to wb_valid high:
  - pass: 1 cycle
  - load: 2 cycles
  - store: no output; the next op can be accepted on the following edge
- Throughput:
  - pass: one per cycle with wb_ready held high
  - load: one per 2 cycles
  - store: one per cycle
- wb_valid and wb_data are registered outputs. in_ready depends combinationally on wb_ready, in WB state only.
- Accept with in_valid = 0 has no effect. Inputs are sampled only on accept edges.

## Test plan
- Reset mid-load: assert rst = 0 while in MEM -> wb_valid = 0, busy = 0, err_cnt = 0 immediately; after release, the first pass op of 0x12345678 appears 1 cycle later.
- Store/load: store 0xDEADBEEF at addr 5, then load addr 5 on the next cycle -> wb_data = 0xDEADBEEF with wb_valid exactly 2 cycles after the load accept.
- Back-to-back pass: pass values 1, 2, 3 on consecutive cycles with wb_ready = 1 -> wb_data 1, 2, 3 on consecutive cycles, in_ready never low.
- Stall: pass 0xA5A5A5A5 with wb_ready = 0 for 4 cycles -> wb_valid and wb_data stable, in_ready = 0, and a second pass presented meanwhile is not accepted until wb_ready = 1.
- Out of range: store to addr 0x0100 then load 0x0100 -> RAM unchanged (reload of addr 0 returns its prior value), load returns 0, err_cnt = 2. Then 260 bad accesses -> err_cnt = 255.
- op = 11 with alu_in = 0x00000042 -> wb_data = 0x00000042 after 1 cycle, err_cnt unchanged.
